// File: rtl/multicycle_control.sv
// Main control FSM for the multicycle MIPS datapath: sequences fetch/decode/execute/
// memory/write-back and decodes every mux select and write strobe from the current state.
module multicycle_control #(
  parameter int MEM_TIMEOUT = 255,
  parameter int CNT_W       = 8
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] opcode,
  input  logic       mem_ready,
  output logic       PCWrite,
  output logic       PCWriteCond,
  output logic       IorD,
  output logic       MemRead,
  output logic       MemWrite,
  output logic       IRWrite,
  output logic       MemtoReg,
  output logic       RegDst,
  output logic       RegWrite,
  output logic       ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [1:0] AluOp,
  output logic [1:0] PCSource,
  output logic [3:0] state,
  output logic       instr_done,
  output logic       illegal_op,
  output logic       mem_error
);

  typedef enum logic [3:0] {
    FETCH      = 4'd0,
    DECODE     = 4'd1,
    MEM_ADDR   = 4'd2,
    MEM_READ   = 4'd3,
    MEM_WB     = 4'd4,
    MEM_WRITE  = 4'd5,
    EXECUTE    = 4'd6,
    R_COMPLETE = 4'd7,
    BRANCH     = 4'd8,
    JUMP       = 4'd9,
    ADDI_EXEC  = 4'd10,
    ADDI_WB    = 4'd11
  } state_t;

  localparam logic [5:0] OP_R    = 6'b000000;
  localparam logic [5:0] OP_LW   = 6'b100011;
  localparam logic [5:0] OP_SW   = 6'b101011;
  localparam logic [5:0] OP_BEQ  = 6'b000100;
  localparam logic [5:0] OP_J    = 6'b000010;
  localparam logic [5:0] OP_ADDI = 6'b001000;

  localparam bit               TMO_EN  = (MEM_TIMEOUT != 0);
  localparam logic [CNT_W-1:0] TMO_VAL = CNT_W'(MEM_TIMEOUT);

  state_t           cur;
  state_t           nxt;
  logic [CNT_W-1:0] wait_cnt;
  logic             mem_state;
  logic             timeout;
  logic             legal_op;

  assign mem_state = (cur == FETCH) || (cur == MEM_READ) || (cur == MEM_WRITE);
  assign timeout   = TMO_EN && mem_state && !mem_ready && (wait_cnt == TMO_VAL);
  assign legal_op  = (opcode == OP_R) || (opcode == OP_LW) || (opcode == OP_SW) ||
                     (opcode == OP_BEQ) || (opcode == OP_J) || (opcode == OP_ADDI);
  assign state     = cur;

  always_comb begin
    nxt = FETCH;
    case (cur)
      FETCH:      nxt = mem_ready ? DECODE : FETCH;
      DECODE: begin
        case (opcode)
          OP_R:          nxt = EXECUTE;
          OP_LW, OP_SW:  nxt = MEM_ADDR;
          OP_BEQ:        nxt = BRANCH;
          OP_J:          nxt = JUMP;
          OP_ADDI:       nxt = ADDI_EXEC;
          default:       nxt = FETCH;
        endcase
      end
      MEM_ADDR: begin
        if (opcode == OP_LW)      nxt = MEM_READ;
        else if (opcode == OP_SW) nxt = MEM_WRITE;
        else                      nxt = FETCH;
      end
      MEM_READ:   nxt = mem_ready ? MEM_WB : (timeout ? FETCH : MEM_READ);
      MEM_WRITE:  nxt = (mem_ready || timeout) ? FETCH : MEM_WRITE;
      EXECUTE:    nxt = R_COMPLETE;
      ADDI_EXEC:  nxt = ADDI_WB;
      default:    nxt = FETCH;
    endcase
  end

  // The wait counter restarts on any state change and after a timeout, so a
  // retried FETCH gets a full wait window again.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cur      <= FETCH;
      wait_cnt <= '0;
    end else begin
      cur <= nxt;
      if (nxt != cur || timeout)
        wait_cnt <= '0;
      else if (mem_state && !mem_ready && wait_cnt != '1)
        wait_cnt <= wait_cnt + CNT_W'(1);
    end
  end

  always_comb begin
    PCWrite     = 1'b0;
    PCWriteCond = 1'b0;
    IorD        = 1'b0;
    MemRead     = 1'b0;
    MemWrite    = 1'b0;
    IRWrite     = 1'b0;
    MemtoReg    = 1'b0;
    RegDst      = 1'b0;
    RegWrite    = 1'b0;
    ALUSrcA     = 1'b0;
    ALUSrcB     = 2'b00;
    AluOp       = 2'b00;
    PCSource    = 2'b00;
    instr_done  = 1'b0;
    illegal_op  = 1'b0;
    case (cur)
      FETCH: begin
        MemRead = 1'b1;
        ALUSrcB = 2'b01;
        IRWrite = mem_ready;
        PCWrite = mem_ready;
      end
      DECODE: begin
        ALUSrcB    = 2'b11;
        illegal_op = !legal_op;
      end
      MEM_ADDR, ADDI_EXEC: begin
        ALUSrcA = 1'b1;
        ALUSrcB = 2'b10;
      end
      MEM_READ: begin
        MemRead = 1'b1;
        IorD    = 1'b1;
      end
      MEM_WB: begin
        RegWrite   = 1'b1;
        MemtoReg   = 1'b1;
        instr_done = 1'b1;
      end
      MEM_WRITE: begin
        MemWrite   = 1'b1;
        IorD       = 1'b1;
        instr_done = mem_ready;
      end
      EXECUTE: begin
        ALUSrcA = 1'b1;
        AluOp   = 2'b10;
      end
      R_COMPLETE: begin
        RegWrite   = 1'b1;
        RegDst     = 1'b1;
        instr_done = 1'b1;
      end
      BRANCH: begin
        ALUSrcA     = 1'b1;
        AluOp       = 2'b01;
        PCWriteCond = 1'b1;
        PCSource    = 2'b01;
        instr_done  = 1'b1;
      end
      JUMP: begin
        PCWrite    = 1'b1;
        PCSource   = 2'b10;
        instr_done = 1'b1;
      end
      ADDI_WB: begin
        RegWrite   = 1'b1;
        instr_done = 1'b1;
      end
      default: ;
    endcase
    mem_error = timeout;
    if (timeout) begin
      PCWrite     = 1'b0;
      PCWriteCond = 1'b0;
      MemWrite    = 1'b0;
      IRWrite     = 1'b0;
      RegWrite    = 1'b0;
    end
    // Reset is asynchronous, so strobes are masked directly to keep them from
    // pulsing while the state register is being forced back to FETCH.
    if (reset) begin
      PCWrite     = 1'b0;
      PCWriteCond = 1'b0;
      MemRead     = 1'b0;
      MemWrite    = 1'b0;
      IRWrite     = 1'b0;
      RegWrite    = 1'b0;
      instr_done  = 1'b0;
      illegal_op  = 1'b0;
      mem_error   = 1'b0;
    end
  end

endmodule

// File: doc/multicycle_control.md
Name: multicycle_control

Overview:
- Main control FSM for the multicycle MIPS datapath. It drives every datapath mux select and write strobe, plus the 2-bit AluOp consumed by the ALU control decoder.
- Sequences each instruction through fetch, decode, execute, memory and write-back states.
- Handshakes with instruction/data memory via mem_ready, with a bounded wait.
- Supported opcodes: R-type, lw, sw, beq, j, addi.

Parameters:
- MEM_TIMEOUT, 255: maximum cycles to wait for mem_ready in any memory state; 0 disables the timeout.
- CNT_W, 8: width of the wait counter; must satisfy 2^CNT_W > MEM_TIMEOUT.

Ports:
- clk  input  1  rising-edge clock
- reset  input  1  asynchronous, active-high reset
- opcode  input  6  instr[31:26] from the instruction register; stable from DECODE until instruction end
- mem_ready  input  1  memory access completes this cycle
- PCWrite  output  1  unconditional PC write
- PCWriteCond  output  1  PC write if ALU zero
- IorD  output  1  memory address select: 0 = PC, 1 = ALUOut
- MemRead  output  1  memory read request
- MemWrite  output  1  memory write request
- IRWrite  output  1  instruction register load
- MemtoReg  output  1  register write data: 1 = MDR, 0 = ALUOut
- RegDst  output  1  destination register: 1 = rd, 0 = rt
- RegWrite  output  1  register file write
- ALUSrcA  output  1  ALU A operand: 0 = PC, 1 = rs
- ALUSrcB  output  2  ALU B operand: 00 = rt, 01 = 4, 10 = sign-extended imm, 11 = sign-extended imm<<2
- AluOp  output  2  to ALU control: 00 = add, 01 = sub, 10 = use funct
- PCSource  output  2  PC source: 00 = ALU result, 01 = ALUOut, 10 = jump target
- state  output  4  current state encoding, for debug
- instr_done  output  1  one-cycle pulse in the final cycle of an instruction
- illegal_op  output  1  one-cycle pulse when DECODE sees an unsupported opcode
- mem_error  output  1  one-cycle pulse on memory timeout

Behaviour:
- Opcodes: R = 000000, lw = 100011, sw = 101011, beq = 000100, j = 000010, addi = 001000.
- State encoding: FETCH = 0, DECODE = 1, MEM_ADDR = 2, MEM_READ = 3, MEM_WB = 4, MEM_WRITE = 5, EXECUTE = 6, R_COMPLETE = 7, BRANCH = 8, JUMP = 9, ADDI_EXEC = 10, ADDI_WB = 11. Values 12–15 are illegal and go to FETCH on the next clock.
- Reset: asynchronous.
  - state = FETCH, wait counter = 0.
  - While reset is high, PCWrite, PCWriteCond, MemRead, MemWrite, IRWrite, RegWrite, instr_done, illegal_op and mem_error are forced to 0.
  - All other outputs show FETCH values.
  - Reset mid-instruction abandons the instruction; no write strobe may glitch high.
- Outputs are decoded combinationally from state. Any output not listed for a state is 0. Gating by mem_ready is noted per state.
- FETCH: MemRead = 1, IorD = 0, ALUSrcA = 0, ALUSrcB = 01, AluOp = 00, PCSource = 00.
  - IRWrite = PCWrite = mem_ready.
  - Goes to DECODE when mem_ready = 1, else stays.
- DECODE: ALUSrcA = 0, ALUSrcB = 11, AluOp = 00 (branch target into ALUOut).
  - R → EXECUTE; lw/sw → MEM_ADDR; beq → BRANCH; j → JUMP; addi → ADDI_EXEC.
  - Any other opcode: illegal_op = 1, next state FETCH.
- MEM_ADDR: ALUSrcA = 1, ALUSrcB = 10, AluOp = 00. lw → MEM_READ, sw → MEM_WRITE.
- MEM_READ: MemRead = 1, IorD = 1. Goes to MEM_WB on mem_ready.
- MEM_WB: RegWrite = 1, MemtoReg = 1, RegDst = 0, instr_done = 1. Goes to FETCH.
- MEM_WRITE: MemWrite = 1, IorD = 1. On mem_ready: instr_done = 1, next state FETCH.
- EXECUTE: ALUSrcA = 1, ALUSrcB = 00, AluOp = 10. Goes to R_COMPLETE.
- R_COMPLETE: RegWrite = 1, RegDst = 1, MemtoReg = 0, instr_done = 1. Goes to FETCH.
- BRANCH: ALUSrcA = 1, ALUSrcB = 00, AluOp = 01, PCWriteCond = 1, PCSource = 01, instr_done = 1. Goes to FETCH.
- JUMP: PCWrite = 1, PCSource = 10, instr_done = 1. Goes to FETCH.
- ADDI_EXEC: ALUSrcA = 1, ALUSrcB = 10, AluOp = 00. Goes to ADDI_WB.
- ADDI_WB: RegWrite = 1, RegDst = 0, MemtoReg = 0, instr_done = 1. Goes to FETCH.
- Wait counter (memory states FETCH, MEM_READ, MEM_WRITE):
  - Cleared on every state change; increments each cycle spent in a memory state without mem_ready.
  - If MEM_TIMEOUT != 0 and the counter reaches MEM_TIMEOUT with mem_ready still 0: mem_error = 1, all write strobes = 0 that cycle, next state FETCH.
  - If mem_ready and timeout coincide, mem_ready wins; mem_error stays 0.
- Latency at zero memory wait, in cycles: R = 4, lw = 5, sw = 4, beq = 3, j = 3, addi = 4.

Test Plan:
- Reset = 1 mid-EXECUTE, release → state = 0, all strobes 0 during reset. First cycle after release: MemRead = 1, ALUSrcB = 01.
- R-type (opcode 000000), mem_ready = 1 → state sequence 0,1,6,7,0. AluOp = 10 in state 6; RegWrite = 1, RegDst = 1 in state 7; instr_done pulses once.
- lw (100011), mem_ready low 3 cycles in MEM_READ → state 3 held 4 cycles, then 4 with RegWrite = 1, MemtoReg = 1. Total 8 cycles.
- sw (101011) then beq (000100) → MemWrite = 1 only in state 5 with IorD = 1. Then BRANCH: AluOp = 01, PCWriteCond = 1, PCSource = 01.
- Opcode 111111 in DECODE → illegal_op = 1 for one cycle, next state 0, no RegWrite/MemWrite asserted.
- MEM_TIMEOUT = 4, mem_ready held 0 in FETCH → mem_error pulses on the 5th cycle and the FSM restarts in FETCH. Repeat with mem_ready = 1 in that same cycle → no mem_error, state 1.
